// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: parity modes and transmitter FSM states.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with a combinational head read and registered occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a character FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          tx,
  output logic                          uart_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned BitPeriod = CLK_FREQ / BAUD;
  localparam int unsigned CntW      = $clog2(BitPeriod + 1);

  tx_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  overflow_q;
  logic                  pop, bit_done, start_frame;
  logic [DATA_BITS-1:0]  head;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (write_en),
    .pop   (pop),
    .wdata (data),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (cnt_q == CntW'(BitPeriod - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = bit_done ? '0 : cnt_q + 1'b1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    tx_d        = tx_q;
    start_frame = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d       = '0;
        start_frame = ~fifo_empty;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_d[0];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            start_frame = ~fifo_empty;
            state_d     = StIdle;
            tx_d        = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Loading the next character overrides the idle transition, so frames abut.
    if (start_frame) begin
      state_d = StStart;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = head;
      par_d   = (^head) ^ (PARITY == PAR_ODD);
      tx_d    = 1'b0;
    end
  end

  assign pop = start_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      overflow_q <= write_en & fifo_full;
    end
  end

  assign tx        = tx_q;
  assign overflow  = overflow_q;
  assign uart_busy = (state_q != StIdle) | ~fifo_empty;

endmodule
